// File: rtl/shifter_scheduler_pkg.sv
// Shared types and width helpers for the shifter scheduler.
// Optional build macro: ROTATE_EN (adds rotate support to shift_core).
package shifter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam int N_DEFAULT  = 3;
    localparam int DW_DEFAULT = 1 << N_DEFAULT;

    // Data width for a given log2 width.
    function automatic int data_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/shifter_scheduler_shift_core.sv
// Combinational bidirectional barrel shifter built from log2(width) mux stages.
// Left operations are done as right operations on the bit-reversed operand.
// Optional build macro: ROTATE_EN (adds the rot input; rotate instead of zero fill).
module shift_core
    import shifter_sched_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int DW = data_width(N)
) (
    input  logic [DW-1:0] a,
    input  logic [N-1:0]  amt,
    input  logic          dir,
`ifdef ROTATE_EN
    input  logic          rot,
`endif
    output logic [DW-1:0] y
);

    logic          rot_en;
    logic [DW-1:0] a_rev;
    logic [DW-1:0] y_rev;
    logic [DW-1:0] stg [N+1];

`ifdef ROTATE_EN
    assign rot_en = rot;
`else
    assign rot_en = 1'b0;
`endif

    // Bit-reverse the operand on the way in and the result on the way out
    always_comb begin
        a_rev = '0;
        y_rev = '0;
        for (int i = 0; i < DW; i++) begin
            a_rev[i] = a[DW-1-i];
            y_rev[i] = stg[N][DW-1-i];
        end
    end

    assign stg[0] = (dir == DIR_LEFT) ? a_rev : a;

    // Stage s moves the word right by 2**s when amt[s] is set
    for (genvar s = 0; s < N; s++) begin : g_stage
        localparam int SH = 1 << s;
        assign stg[s+1] = amt[s] ? (rot_en ? {stg[s][SH-1:0], stg[s][DW-1:SH]}
                                           : (stg[s] >> SH))
                                 : stg[s];
    end

    assign y = (dir == DIR_LEFT) ? y_rev : stg[N];

endmodule

// File: rtl/shifter_scheduler.sv
// Round-robin scheduler sharing one barrel shifter among NREQ requesters.
// Flow: IDLE grants one request, EXEC computes, RESP holds the tagged result
// until the consumer takes it.
// Optional build macro: ROTATE_EN (adds req_rot and rotate operations).
module shifter_scheduler
    import shifter_sched_pkg::*;
#(
    parameter  int N    = N_DEFAULT,
    parameter  int NREQ = 2,
    parameter  int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int DW   = data_width(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_dir,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*N-1:0]  req_amt,
`ifdef ROTATE_EN
    input  logic [NREQ-1:0]    req_rot,
`endif
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_y,
    output logic [IDW-1:0]     rsp_id
);

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [DW-1:0]  a_q;
    logic [N-1:0]   amt_q;
    logic           dir_q;
    logic           rot_q;
    logic [IDW-1:0] id_q;
    logic           rsp_valid_q;
    logic [DW-1:0]  rsp_y_q;
    logic [IDW-1:0] rsp_id_q;

    logic           found;
    int             grant_int;
    logic [DW-1:0]  core_y;

    // Find the first valid requester starting at the round-robin pointer
    always_comb begin
        found     = 1'b0;
        grant_int = 0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_int = idx;
            end
        end
    end

    // Grant is combinational in IDLE and forced low while reset is held
    always_comb begin
        req_ready = '0;
        if (reset_n && state_q == IDLE && found) begin
            req_ready[grant_int] = 1'b1;
        end
    end

    shift_core #(.N(N)) u_shift_core (
        .a   (a_q),
        .amt (amt_q),
        .dir (dir_q),
`ifdef ROTATE_EN
        .rot (rot_q),
`endif
        .y   (core_y)
    );

    // Scheduler FSM: grant, execute, hold response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            amt_q       <= '0;
            dir_q       <= 1'b0;
            rot_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        a_q      <= req_a[grant_int*DW +: DW];
                        amt_q    <= req_amt[grant_int*N +: N];
                        dir_q    <= req_dir[grant_int];
`ifdef ROTATE_EN
                        rot_q    <= req_rot[grant_int];
`else
                        rot_q    <= 1'b0;
`endif
                        id_q     <= IDW'(grant_int);
                        rr_ptr_q <= IDW'((grant_int + 1) % NREQ);
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_q     <= core_y;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shifter_scheduler.sv
// Directed bench for shifter_scheduler at N=3, NREQ=2.
// Build with ROTATE_EN defined to include the rotate scenario.
module tb_shifter_scheduler;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_dir;
    logic [15:0] req_a;
    logic [5:0]  req_amt;
    logic [1:0]  req_rot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_y;
    logic [0:0]  rsp_id;

    int checks;
    int errors;

    shifter_scheduler #(.N(3), .NREQ(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .req_a     (req_a),
        .req_amt   (req_amt),
`ifdef ROTATE_EN
        .req_rot   (req_rot),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int idx, input logic [7:0] a, input logic [2:0] amt,
                           input logic dir, input logic rot, input logic v);
        req_valid[idx]         = v;
        req_a[idx*8 +: 8]      = a;
        req_amt[idx*3 +: 3]    = amt;
        req_dir[idx]           = dir;
        req_rot[idx]           = rot;
    endtask

    // Issue one request and collect its response; ok=0 on any timeout
    task automatic run_one(input int idx, input logic [7:0] a, input logic [2:0] amt,
                           input logic dir, input logic rot,
                           output logic [7:0] y, output logic [0:0] id, output logic ok);
        int n;
        ok = 1'b1;
        y  = '0;
        id = '0;
        set_req(idx, a, amt, dir, rot, 1'b1);
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready[idx]) ok = 1'b0;
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!rsp_valid) ok = 1'b0;
        y  = rsp_y;
        id = rsp_id;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_dir   = '0;
        req_a     = '0;
        req_amt   = '0;
        req_rot   = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready got %b want 00", req_ready);
        end
        checks++;
        if ({rsp_valid, rsp_y, rsp_id} !== 10'd0) begin
            errors++; $display("FAIL reset_rsp got v=%b y=%h id=%h want 0/00/0", rsp_valid, rsp_y, rsp_id);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant got %b want 01", req_ready);
        end
        apply_reset();
    endtask

    task automatic test_single();
        set_req(0, 8'hD2, 3'd3, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL single_ready got %b want 01", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL single_exec got v=%b rdy=%b want 0/00", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_y !== 8'h1A || rsp_id !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v=%b y=%h id=%h want 1/1a/0", rsp_valid, rsp_y, rsp_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_accept got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_shifts();
        logic [7:0]  ta  [6] = '{8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h81, 8'h81};
        logic [2:0]  tam [6] = '{3'd3,  3'd0,  3'd7,  3'd7,  3'd1,  3'd1};
        logic        tdr [6] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1};
        int          tid [6] = '{1,     1,     1,     0,     0,     1};
        logic [7:0]  ty  [6] = '{8'h90, 8'hD2, 8'h00, 8'h01, 8'h40, 8'h02};
        logic [7:0]  y;
        logic [0:0]  id;
        logic        ok;
        for (int i = 0; i < 6; i++) begin
            run_one(tid[i], ta[i], tam[i], tdr[i], 1'b0, y, id, ok);
            checks++;
            if (!ok || y !== ty[i] || id !== 1'(tid[i])) begin
                errors++;
                $display("FAIL shift_vec%0d got ok=%b y=%h id=%h want y=%h id=%0d",
                         i, ok, y, id, ty[i], tid[i]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] gr [4];
        logic [0:0] ids [4];
        int ng, nr;
        apply_reset();
        set_req(0, 8'h0F, 3'd1, 1'b1, 1'b0, 1'b1);
        set_req(1, 8'hF0, 3'd2, 1'b0, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        #1;
        ng = 0; nr = 0;
        for (int c = 0; c < 40 && (ng < 4 || nr < 4); c++) begin
            if (req_ready != 2'b00 && ng < 4) begin gr[ng] = req_ready; ng++; end
            if (rsp_valid && nr < 4) begin ids[nr] = rsp_id; nr++; end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        checks++;
        if (ng != 4 || nr != 4) begin
            errors++; $display("FAIL fair_count got grants=%0d rsps=%0d want 4/4", ng, nr);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (gr[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || ids[k] !== 1'(k % 2)) begin
                    errors++;
                    $display("FAIL fair_grant%0d got rdy=%b id=%h want rdy=%b id=%0d",
                             k, gr[k], ids[k], (k % 2 == 0) ? 2'b01 : 2'b10, k % 2);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_skip();
        logic [7:0] y;
        logic [0:0] id;
        logic       ok;
        apply_reset();
        // requester 0 raises then drops while the shifter is busy with requester 1
        set_req(1, 8'h3C, 3'd2, 1'b1, 1'b0, 1'b1);
        #1;
        @(posedge clk); #1;
        set_req(0, 8'hAA, 3'd1, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL skip_grant got %b want 10", req_ready);
        end
        run_one(1, 8'h3C, 3'd2, 1'b1, 1'b0, y, id, ok);
        req_valid = 2'b00;
        checks++;
        if (!ok || y !== 8'hF0 || id !== 1'b1) begin
            errors++; $display("FAIL skip_rsp got ok=%b y=%h id=%h want f0/1", ok, y, id);
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        set_req(0, 8'hB4, 3'd2, 1'b0, 1'b0, 1'b1);
        #1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 8'h11, 3'd1, 1'b1, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_y !== 8'h2D || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b y=%h id=%h rdy=%b want 1/2d/0/00",
                         c, rsp_valid, rsp_y, rsp_id, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b10) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/10", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_midop();
        logic [7:0] y;
        logic [0:0] id;
        logic       ok;
        apply_reset();
        set_req(1, 8'hD2, 3'd1, 1'b0, 1'b0, 1'b1);
        #1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        // now in EXEC
        reset_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
            errors++; $display("FAIL midrst_async got v=%b rdy=%b want 0/00", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_hold got v=%b want 0", rsp_valid);
        end
        req_valid = 2'b11;
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL midrst_ptr got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        run_one(0, 8'h5A, 3'd4, 1'b1, 1'b0, y, id, ok);
        checks++;
        if (!ok || y !== 8'hA0 || id !== 1'b0) begin
            errors++; $display("FAIL midrst_next got ok=%b y=%h id=%h want a0/0", ok, y, id);
        end
    endtask

`ifdef ROTATE_EN
    task automatic test_rotate();
        logic [7:0] y;
        logic [0:0] id;
        logic       ok;
        run_one(0, 8'hD2, 3'd3, 1'b0, 1'b1, y, id, ok);
        checks++;
        if (!ok || y !== 8'h5A) begin
            errors++; $display("FAIL rot_right got ok=%b y=%h want 5a", ok, y);
        end
        run_one(1, 8'hD2, 3'd3, 1'b1, 1'b1, y, id, ok);
        checks++;
        if (!ok || y !== 8'h96) begin
            errors++; $display("FAIL rot_left got ok=%b y=%h want 96", ok, y);
        end
        req_rot = 2'b00;
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        req_valid = '0;
        req_dir   = '0;
        req_a     = '0;
        req_amt   = '0;
        req_rot   = '0;
        rsp_ready = 1'b0;
        reset_n   = 1'b0;
        test_reset();
        test_single();
        test_shifts();
        test_fairness();
        test_skip();
        test_backpressure();
        test_reset_midop();
`ifdef ROTATE_EN
        test_rotate();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_scheduler.md
Name: shifter_scheduler

Overview:
Round-robin scheduler that shares one bidirectional barrel shifter among NREQ requesters. It accepts one request at a time over per-requester valid/ready handshakes, drives the shared shifter, and registers the result. The result returns on a single response channel tagged with the requester ID. It sits between the lab's client logic (e.g. LED/switch front-ends) and the shift datapath.

Parameters:
N, 3, log2 of data width; data is 2**N bits wide, amt is N bits wide
NREQ, 2, number of requesters (2..8)
IDW, $clog2(NREQ) (min 1), response ID width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
req_dir  in  NREQ  per-requester direction: 0 = right (logical), 1 = left
req_a  in  NREQ*2**N  packed operands; requester i uses slice [i*2**N +: 2**N]
req_amt  in  NREQ*N  packed shift amounts; requester i uses slice [i*N +: N]
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_y  out  2**N  shifted result
rsp_id  out  IDW  index of the requester that owns rsp_y

Behaviour:
- Single clock (clk). Asynchronous active-low reset (reset_n).
- Reset values:
  - state = IDLE
  - req_ready = 0
  - rsp_valid = 0
  - rsp_y = 0
  - rsp_id = 0
  - round-robin pointer rr_ptr = 0
  - operand/amt/dir latches = 0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Search for the first set req_valid starting at rr_ptr, wrapping modulo NREQ.
  - If one is found (index g), assert req_ready[g] combinationally in the same cycle.
  - On that edge, latch req_a, req_amt and req_dir of g, and the ID g.
  - Set rr_ptr = (g+1) mod NREQ and go to EXEC.
  - If no request is valid, stay in IDLE and leave rr_ptr unchanged.
- EXEC:
  - The latched operands drive shift_core.
  - On the edge, register its output into rsp_y and the latched ID into rsp_id.
  - Set rsp_valid = 1 and go to RESP.
  - req_ready = 0 in this state.
- RESP:
  - Hold rsp_valid, rsp_y and rsp_id stable until rsp_ready = 1.
  - On the accepting edge, clear rsp_valid and go to IDLE.
  - req_ready = 0 in this state; no new request is accepted in the same cycle the response is accepted.
- Latency: request accepted at edge t; rsp_valid rises after edge t+1. Minimum request-to-request throughput is 3 cycles per request.
- Arithmetic:
  - Right shift is logical (zero fill); left shift is zero fill.
  - amt = 0 passes the operand through unchanged.
  - amt = 2**N-1 (7 at defaults) is the maximum; there is no out-of-range case.
- Boundaries:
  - All requesters valid: grants rotate 0,1,...,NREQ-1,0; no requester is starved.
  - A requester may drop req_valid before it is granted; it is then skipped without error.
  - rsp_ready held high before RESP has no effect.
  - reset_n asserted mid-operation (EXEC/RESP) returns to IDLE immediately; the in-flight result is discarded and rsp_valid drops asynchronously.

Optional Feature:
Macro ROTATE_EN.
- Defined:
  - Adds an input port req_rot (NREQ bits).
  - When the granted requester's req_rot bit is 1, shift_core performs a rotate in the direction given by req_dir instead of a shift.
  - req_rot is latched together with the other operands.
- Undefined: the port is absent and only logical shifts are performed.

Decomposition:
- Package shifter_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t
  - typedef enum logic {DIR_RIGHT = 0, DIR_LEFT = 1} dir_t
  - localparam helpers for data width (2**N)
- Sub-module shift_core (purely combinational, parameter N):
  - Inputs a, amt, dir, and rot under ROTATE_EN; output y.
  - Implemented as log-stage muxing.
- The scheduler instantiates exactly one shift_core.

Test Plan:
- Single request: reset; requester 0 sends a=8'hD2, amt=3, dir=right → req_ready[0] high in the same cycle; rsp_valid two edges later with rsp_y=8'h1A, rsp_id=0.
- Left shift and edges: requester 1 sends a=8'hD2, dir=left, amt=3 → 8'h90. Same operand with amt=0 → 8'hD2. Same operand, left, amt=7 → 8'h00.
- Contention fairness: both requesters hold valid continuously with rsp_ready=1 → grant order 0,1,0,1; rsp_id matches each grant.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_y and rsp_id stay stable and req_ready stays 0; rsp_ready=1 → returns to IDLE next edge.
- Reset mid-operation: assert reset_n=0 while in EXEC → rsp_valid=0, req_ready=0, rr_ptr=0; the next request after release is served normally.
- ROTATE_EN build: a=8'hD2, amt=3, rot=1 → right rotate gives 8'h5A, left rotate gives 8'h96.
